// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg: shared definitions for the RV64 execute stage.
//   XLEN_DEFAULT   default datapath width
//   ALU_*          ALU operation codes (base set plus the extended set that is
//                  only decoded when EX_ALU_EXT_EN is defined)
//   FWD_*          forwarding-select encodings
//   ex_ctrl_t      control bits carried from EX into MEM
//   fwd_sel()      forwarding priority rule shared by both operands
// ---------------------------------------------------------------------------
package ex_pkg;

   localparam int XLEN_DEFAULT = 64;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   localparam logic [1:0] FWD_ID  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic branch;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic regwrite;
   } ex_ctrl_t;

   // EX/MEM wins over MEM/WB because it holds the younger result; x0 is
   // hardwired to zero and must never be replaced by a forwarded value.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] mem_rd,
                                          input logic       mem_rw,
                                          input logic [4:0] wb_rd,
                                          input logic       wb_rw);
      if (mem_rw && (mem_rd != 5'd0) && (mem_rd == rs)) begin
         return FWD_MEM;
      end else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == rs)) begin
         return FWD_WB;
      end else begin
         return FWD_ID;
      end
   endfunction

endpackage

// File: rtl/ex_alu.sv
// ---------------------------------------------------------------------------
// ex_alu: combinational XLEN-bit ALU with zero flag.
//   alu_ctrl  in   4     operation code (ex_pkg ALU_*)
//   op_a      in   XLEN  operand A
//   op_b      in   XLEN  operand B (bits [5:0] are the shift amount)
//   result    out  XLEN  operation result, 0 for undecoded codes
//   zero      out  1     result == 0
// Macro EX_ALU_EXT_EN enables XOR/SLL/SRL/SLT/SLTU/SRA; without it those
// codes decode as "other" and give 0.
// ---------------------------------------------------------------------------
module ex_alu
   import ex_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] result,
   output logic            zero
);

`ifdef EX_ALU_EXT_EN
   logic signed [XLEN-1:0] op_a_s;
   logic signed [XLEN-1:0] op_b_s;
   logic        [5:0]      shamt;

   assign op_a_s = op_a;
   assign op_b_s = op_b;
   assign shamt  = op_b[5:0];
`endif

   always_comb begin
      result = '0;
      case (alu_ctrl)
         ALU_AND:  result = op_a & op_b;
         ALU_OR:   result = op_a | op_b;
         ALU_ADD:  result = op_a + op_b;
         ALU_SUB:  result = op_a - op_b;
`ifdef EX_ALU_EXT_EN
         ALU_XOR:  result = op_a ^ op_b;
         ALU_SLL:  result = op_a << shamt;
         ALU_SRL:  result = op_a >> shamt;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         ALU_SRA:  result = op_a_s >>> shamt;
`endif
         default:  result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/ex_stage_fwd_alu.sv
// ---------------------------------------------------------------------------
// ex_stage_fwd_alu: execute stage of the 5-stage RV64 pipeline.
//   Forwarding unit (EX/MEM and MEM/WB), operand muxes, ALU, branch-target
//   adder and the EX/MEM pipeline register.
// Ports:
//   clk, rst                clock (rising edge), async active-low reset
//   id_ex_*                 operands, addresses and control from ID/EX
//   flush                   zero the control bits entering EX/MEM
//   mem_wb_rd/regwrite/data MEM/WB write-back info for forwarding
//   forward_a/forward_b     combinational forwarding selects
//   ex_mem_*                registered results and control for MEM
// Macro EX_ALU_EXT_EN (see ex_alu) enables the extended ALU codes.
// ---------------------------------------------------------------------------
module ex_stage_fwd_alu
   import ex_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] id_ex_pc,
   input  logic [XLEN-1:0] id_ex_rd1,
   input  logic [XLEN-1:0] id_ex_rd2,
   input  logic [XLEN-1:0] id_ex_imm,
   input  logic [4:0]      id_ex_rs1,
   input  logic [4:0]      id_ex_rs2,
   input  logic [4:0]      id_ex_rd,
   input  logic            id_ex_alusrc,
   input  logic [3:0]      id_ex_alu_ctrl,
   input  logic            id_ex_branch,
   input  logic            id_ex_memread,
   input  logic            id_ex_memwrite,
   input  logic            id_ex_memtoreg,
   input  logic            id_ex_regwrite,
   input  logic            flush,
   input  logic [4:0]      mem_wb_rd,
   input  logic            mem_wb_regwrite,
   input  logic [XLEN-1:0] mem_wb_data,
   output logic [1:0]      forward_a,
   output logic [1:0]      forward_b,
   output logic [XLEN-1:0] ex_mem_pc,
   output logic            ex_mem_zero,
   output logic [XLEN-1:0] ex_mem_alu_result,
   output logic [XLEN-1:0] ex_mem_store_data,
   output logic [4:0]      ex_mem_rd,
   output logic            ex_mem_branch,
   output logic            ex_mem_memread,
   output logic            ex_mem_memwrite,
   output logic            ex_mem_memtoreg,
   output logic            ex_mem_regwrite
);

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   logic [XLEN-1:0] pc_d,     pc_q;
   logic            zero_d,   zero_q;
   logic [XLEN-1:0] result_d, result_q;
   logic [XLEN-1:0] store_d,  store_q;
   logic [4:0]      rd_d,     rd_q;
   ex_ctrl_t        ctrl_d,   ctrl_q;

   // Forwarding compares against the EX/MEM register outputs, so a reset
   // (regwrite cleared) automatically disables EX/MEM forwarding.
   always_comb begin
      forward_a = fwd_sel(id_ex_rs1, rd_q, ctrl_q.regwrite, mem_wb_rd, mem_wb_regwrite);
      forward_b = fwd_sel(id_ex_rs2, rd_q, ctrl_q.regwrite, mem_wb_rd, mem_wb_regwrite);
   end

   // Select 11 is unused and falls back to the ID/EX value.
   always_comb begin
      case (forward_a)
         FWD_WB:  op_a = mem_wb_data;
         FWD_MEM: op_a = result_q;
         default: op_a = id_ex_rd1;
      endcase
      case (forward_b)
         FWD_WB:  fwd_b = mem_wb_data;
         FWD_MEM: fwd_b = result_q;
         default: fwd_b = id_ex_rd2;
      endcase
      // Immediate selection happens after forwarding so stores still see
      // the forwarded rs2 value.
      op_b = id_ex_alusrc ? id_ex_imm : fwd_b;
   end

   ex_alu #(
      .XLEN(XLEN)
   ) u_alu (
      .alu_ctrl(id_ex_alu_ctrl),
      .op_a    (op_a),
      .op_b    (op_b),
      .result  (alu_result),
      .zero    (alu_zero)
   );

   always_comb begin
      pc_d     = id_ex_pc + (id_ex_imm << 1);
      zero_d   = alu_zero;
      result_d = alu_result;
      store_d  = fwd_b;
      rd_d     = id_ex_rd;
      ctrl_d   = '{branch:   id_ex_branch,
                   memread:  id_ex_memread,
                   memwrite: id_ex_memwrite,
                   memtoreg: id_ex_memtoreg,
                   regwrite: id_ex_regwrite};
      // A flush turns the instruction into a bubble; data fields are
      // don't-care once all control is clear, so they latch normally.
      if (flush) begin
         ctrl_d = '0;
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= '0;
         zero_q   <= 1'b0;
         result_q <= '0;
         store_q  <= '0;
         rd_q     <= '0;
         ctrl_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         zero_q   <= zero_d;
         result_q <= result_d;
         store_q  <= store_d;
         rd_q     <= rd_d;
         ctrl_q   <= ctrl_d;
      end
   end

   assign ex_mem_pc         = pc_q;
   assign ex_mem_zero       = zero_q;
   assign ex_mem_alu_result = result_q;
   assign ex_mem_store_data = store_q;
   assign ex_mem_rd         = rd_q;
   assign ex_mem_branch     = ctrl_q.branch;
   assign ex_mem_memread    = ctrl_q.memread;
   assign ex_mem_memwrite   = ctrl_q.memwrite;
   assign ex_mem_memtoreg   = ctrl_q.memtoreg;
   assign ex_mem_regwrite   = ctrl_q.regwrite;

endmodule

// File: tb/tb_ex_stage_fwd_alu.sv
module tb_ex_stage_fwd_alu;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] id_ex_pc, id_ex_rd1, id_ex_rd2, id_ex_imm;
   logic [4:0]      id_ex_rs1, id_ex_rs2, id_ex_rd;
   logic            id_ex_alusrc;
   logic [3:0]      id_ex_alu_ctrl;
   logic            id_ex_branch, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_regwrite;
   logic            flush;
   logic [4:0]      mem_wb_rd;
   logic            mem_wb_regwrite;
   logic [XLEN-1:0] mem_wb_data;
   logic [1:0]      forward_a, forward_b;
   logic [XLEN-1:0] ex_mem_pc, ex_mem_alu_result, ex_mem_store_data;
   logic            ex_mem_zero;
   logic [4:0]      ex_mem_rd;
   logic            ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg, ex_mem_regwrite;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_stage_fwd_alu #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .id_ex_pc(id_ex_pc), .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2), .id_ex_imm(id_ex_imm),
      .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_alusrc(id_ex_alusrc), .id_ex_alu_ctrl(id_ex_alu_ctrl),
      .id_ex_branch(id_ex_branch), .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
      .id_ex_memtoreg(id_ex_memtoreg), .id_ex_regwrite(id_ex_regwrite),
      .flush(flush), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_data(mem_wb_data),
      .forward_a(forward_a), .forward_b(forward_b),
      .ex_mem_pc(ex_mem_pc), .ex_mem_zero(ex_mem_zero), .ex_mem_alu_result(ex_mem_alu_result),
      .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd(ex_mem_rd),
      .ex_mem_branch(ex_mem_branch), .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
      .ex_mem_memtoreg(ex_mem_memtoreg), .ex_mem_regwrite(ex_mem_regwrite)
   );

   // All registered outputs concatenated, for reset checks.
   logic [3*XLEN+5+6-1:0] all_out;
   assign all_out = {ex_mem_pc, ex_mem_zero, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
                     ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg, ex_mem_regwrite};
   logic [4:0] ctrl_out;
   assign ctrl_out = {ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg, ex_mem_regwrite};

   // Reference model state: what EX/MEM should hold.
   logic [XLEN-1:0] m_pc, m_res, m_store;
   logic            m_zero;
   logic [4:0]      m_rd;
   logic [4:0]      m_ctrl;   // {branch, memread, memwrite, memtoreg, regwrite}

   function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] code,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
      int sh;
      sh = int'(b[5:0]);
      case (code)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd6: return a - b;
`ifdef EX_ALU_EXT_EN
         4'd3:  return a ^ b;
         4'd4:  return a << sh;
         4'd5:  return a >> sh;
         4'd7:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4'd8:  return (a < b) ? 64'd1 : 64'd0;
         4'd13: return $signed(a) >>> sh;
`endif
         default: return '0;
      endcase
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (m_ctrl[0] && m_rd != 0 && m_rd == rs) return 2'b10;
      if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic drive_idle();
      id_ex_pc = '0; id_ex_rd1 = '0; id_ex_rd2 = '0; id_ex_imm = '0;
      id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
      id_ex_alusrc = 1'b0; id_ex_alu_ctrl = 4'd0;
      id_ex_branch = 1'b0; id_ex_memread = 1'b0; id_ex_memwrite = 1'b0;
      id_ex_memtoreg = 1'b0; id_ex_regwrite = 1'b0;
      flush = 1'b0; mem_wb_rd = '0; mem_wb_regwrite = 1'b0; mem_wb_data = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loads EX/MEM with rd / regwrite / result = a (ADD a + 0, no forwarding).
   task automatic preload(input logic [4:0] rd, input logic rw, input logic [XLEN-1:0] a);
      drive_idle();
      id_ex_rd1 = a; id_ex_alu_ctrl = 4'b0010; id_ex_rd = rd; id_ex_regwrite = rw;
      tick();
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b0;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL reset_initial got=%h exp=0", all_out);
      end
      tick(); tick();
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL reset_hold got=%h exp=0", all_out);
      end
      rst = 1'b1;
      #1;
   endtask

   task automatic test_ex_forward();
      preload(5'd5, 1'b1, 64'd100);
      drive_idle();
      id_ex_rs1 = 5'd5; id_ex_rs2 = 5'd6; id_ex_rd1 = 64'd999; id_ex_rd2 = 64'd7;
      id_ex_alu_ctrl = 4'b0010; id_ex_rd = 5'd8; id_ex_regwrite = 1'b1;
      #1;
      checks++;
      if (forward_a !== 2'b10 || forward_b !== 2'b00) begin
         errors++; $display("FAIL ex_fwd_sel got=%b/%b exp=10/00", forward_a, forward_b);
      end
      tick();
      checks++;
      if (ex_mem_alu_result !== 64'd107) begin
         errors++; $display("FAIL ex_fwd_result got=%0d exp=107", ex_mem_alu_result);
      end
   endtask

   task automatic test_double_hazard();
      preload(5'd3, 1'b1, 64'd10);
      drive_idle();
      mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1; mem_wb_data = 64'd20;
      id_ex_rs1 = 5'd3; id_ex_rs2 = 5'd9; id_ex_rd2 = 64'd4; id_ex_alu_ctrl = 4'b0110;
      #1;
      checks++;
      if (forward_a !== 2'b10) begin
         errors++; $display("FAIL double_hazard_sel got=%b exp=10", forward_a);
      end
      tick();
      checks++;
      if (ex_mem_alu_result !== 64'd6 || ex_mem_zero !== 1'b0) begin
         errors++; $display("FAIL double_hazard_result got=%0d z=%b exp=6 z=0", ex_mem_alu_result, ex_mem_zero);
      end
   endtask

   task automatic test_x0_wb();
      preload(5'd0, 1'b1, 64'd77);
      drive_idle();
      mem_wb_rd = 5'd2; mem_wb_regwrite = 1'b1; mem_wb_data = 64'd9;
      id_ex_rs1 = 5'd0; id_ex_rs2 = 5'd2; id_ex_rd1 = 64'd15; id_ex_rd2 = 64'd123;
      id_ex_alu_ctrl = 4'b0000;
      #1;
      checks++;
      if (forward_a !== 2'b00 || forward_b !== 2'b01) begin
         errors++; $display("FAIL x0_wb_sel got=%b/%b exp=00/01", forward_a, forward_b);
      end
      tick();
      checks++;
      if (ex_mem_alu_result !== 64'd9 || ex_mem_store_data !== 64'd9) begin
         errors++; $display("FAIL x0_wb_result got=%0d/%0d exp=9/9", ex_mem_alu_result, ex_mem_store_data);
      end
   endtask

   task automatic test_branch_flush();
      drive_idle();
      id_ex_pc = 64'h100; id_ex_imm = 64'd8; id_ex_rd1 = 64'd4; id_ex_rd2 = 64'd4;
      id_ex_alu_ctrl = 4'b0110; id_ex_branch = 1'b1;
      tick();
      checks++;
      if (ex_mem_pc !== 64'h110 || ex_mem_zero !== 1'b1 || ex_mem_branch !== 1'b1) begin
         errors++; $display("FAIL branch got pc=%h z=%b br=%b exp pc=110 z=1 br=1", ex_mem_pc, ex_mem_zero, ex_mem_branch);
      end
      id_ex_memread = 1'b1; id_ex_memwrite = 1'b1; id_ex_memtoreg = 1'b1; id_ex_regwrite = 1'b1;
      id_ex_rd = 5'd12; flush = 1'b1;
      tick();
      checks++;
      if (ctrl_out !== 5'b0 || ex_mem_pc !== 64'h110 || ex_mem_rd !== 5'd12 || ex_mem_zero !== 1'b1) begin
         errors++; $display("FAIL flush got ctrl=%b pc=%h rd=%0d z=%b exp ctrl=00000 pc=110 rd=12 z=1",
                            ctrl_out, ex_mem_pc, ex_mem_rd, ex_mem_zero);
      end
   endtask

   task automatic test_imm_undef();
      drive_idle();
      flush = 1'b1;
      tick();
      drive_idle();
      mem_wb_rd = 5'd4; mem_wb_regwrite = 1'b1; mem_wb_data = 64'd50;
      id_ex_rs2 = 5'd4; id_ex_rd2 = 64'd0; id_ex_alusrc = 1'b1; id_ex_imm = '1;
      id_ex_rd1 = 64'd1; id_ex_alu_ctrl = 4'b0010;
      #1;
      checks++;
      if (forward_b !== 2'b01) begin
         errors++; $display("FAIL imm_fwd_sel got=%b exp=01", forward_b);
      end
      tick();
      checks++;
      if (ex_mem_alu_result !== 64'd0 || ex_mem_zero !== 1'b1 || ex_mem_store_data !== 64'd50) begin
         errors++; $display("FAIL imm_add got=%0d z=%b st=%0d exp=0 z=1 st=50",
                            ex_mem_alu_result, ex_mem_zero, ex_mem_store_data);
      end
      id_ex_alusrc = 1'b0; id_ex_rd1 = 64'd5; id_ex_alu_ctrl = 4'b1111;
      tick();
      checks++;
      if (ex_mem_alu_result !== 64'd0 || ex_mem_zero !== 1'b1) begin
         errors++; $display("FAIL undef_code got=%0d z=%b exp=0 z=1", ex_mem_alu_result, ex_mem_zero);
      end
   endtask

   task automatic test_reset_midrun();
      drive_idle();
      id_ex_pc = 64'h40; id_ex_imm = 64'd2; id_ex_rd1 = 64'd3; id_ex_rd2 = 64'd5;
      id_ex_alu_ctrl = 4'b0010; id_ex_rd = 5'd7; id_ex_branch = 1'b1; id_ex_memread = 1'b1;
      id_ex_memwrite = 1'b1; id_ex_memtoreg = 1'b1; id_ex_regwrite = 1'b1;
      tick();
      checks++;
      if (ex_mem_alu_result !== 64'd8 || ex_mem_pc !== 64'h44 || ctrl_out !== 5'b11111) begin
         errors++; $display("FAIL midrun_load got res=%0d pc=%h ctrl=%b exp 8 44 11111",
                            ex_mem_alu_result, ex_mem_pc, ctrl_out);
      end
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL midrun_async got=%h exp=0", all_out);
      end
      tick(); tick();
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL midrun_hold got=%h exp=0", all_out);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL midrun_release_early got=%h exp=0", all_out);
      end
      tick();
      checks++;
      if (ex_mem_alu_result !== 64'd8 || ex_mem_rd !== 5'd7 || ctrl_out !== 5'b11111) begin
         errors++; $display("FAIL midrun_release got res=%0d rd=%0d ctrl=%b exp 8 7 11111",
                            ex_mem_alu_result, ex_mem_rd, ctrl_out);
      end
   endtask

   task automatic test_random();
      logic [3:0] codes [12];
      logic [XLEN-1:0] a, fb, b, r, e_pc;
      logic [1:0] ea, eb;
      logic [4:0] e_ctrl;
      codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd13, 4'd15, 4'd9};
      drive_idle();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      m_pc = '0; m_res = '0; m_store = '0; m_zero = 1'b0; m_rd = '0; m_ctrl = '0;
      for (int i = 0; i < 200; i++) begin
         id_ex_pc  = {$urandom(), $urandom()};
         id_ex_rd1 = (i % 5 == 0) ? 64'(i) : {$urandom(), $urandom()};
         id_ex_rd2 = (i % 5 == 0) ? 64'(i) : {$urandom(), $urandom()};
         id_ex_imm = {$urandom(), $urandom()};
         id_ex_rs1 = 5'($urandom_range(0, 3));
         id_ex_rs2 = 5'($urandom_range(0, 3));
         id_ex_rd  = 5'($urandom_range(0, 3));
         id_ex_alusrc   = ($urandom_range(0, 3) == 0);
         id_ex_alu_ctrl = codes[$urandom_range(0, 11)];
         {id_ex_branch, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_regwrite} = 5'($urandom());
         flush = ($urandom_range(0, 7) == 0);
         mem_wb_rd = 5'($urandom_range(0, 3));
         mem_wb_regwrite = $urandom_range(0, 1) == 1;
         mem_wb_data = {$urandom(), $urandom()};
         #1;
         ea = ref_fwd(id_ex_rs1);
         eb = ref_fwd(id_ex_rs2);
         a  = (ea == 2'b10) ? m_res : (ea == 2'b01) ? mem_wb_data : id_ex_rd1;
         fb = (eb == 2'b10) ? m_res : (eb == 2'b01) ? mem_wb_data : id_ex_rd2;
         b  = id_ex_alusrc ? id_ex_imm : fb;
         r  = ref_alu(id_ex_alu_ctrl, a, b);
         e_pc = id_ex_pc + id_ex_imm * 2;
         e_ctrl = flush ? 5'b0 : {id_ex_branch, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_regwrite};
         checks++;
         if (forward_a !== ea || forward_b !== eb) begin
            errors++; $display("FAIL rand_fwd[%0d] got=%b/%b exp=%b/%b", i, forward_a, forward_b, ea, eb);
         end
         tick();
         m_pc = e_pc; m_res = r; m_zero = (r == 0); m_store = fb; m_rd = id_ex_rd; m_ctrl = e_ctrl;
         checks++;
         if (ex_mem_alu_result !== m_res || ex_mem_zero !== m_zero || ex_mem_store_data !== m_store) begin
            errors++; $display("FAIL rand_alu[%0d] code=%b got=%h z=%b st=%h exp=%h z=%b st=%h", i, id_ex_alu_ctrl,
                               ex_mem_alu_result, ex_mem_zero, ex_mem_store_data, m_res, m_zero, m_store);
         end
         checks++;
         if (ex_mem_pc !== m_pc || ex_mem_rd !== m_rd || ctrl_out !== m_ctrl) begin
            errors++; $display("FAIL rand_reg[%0d] got pc=%h rd=%0d ctrl=%b exp pc=%h rd=%0d ctrl=%b", i,
                               ex_mem_pc, ex_mem_rd, ctrl_out, m_pc, m_rd, m_ctrl);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_ex_forward();
      test_double_hazard();
      test_x0_wb();
      test_branch_flush();
      test_imm_undef();
      test_reset_midrun();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
